// File: rtl/seg7_scan_driver_pkg.sv
// Shared constants for the seven-segment scan driver: active-low segment codes
// and the prescaler width helper.
package seg7_pkg;

  localparam logic [6:0] SEG_OFF  = 7'h7F;
  localparam logic [6:0] SEG_DASH = 7'b0111111;

  // Active-low {g,f,e,d,c,b,a} patterns, indexed by BCD value 0..9.
  localparam logic [9:0][6:0] DIGIT_CODES = {
    7'b0010000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

  function automatic int prescaler_width(input int div);
    return (div <= 2) ? 1 : $clog2(div);
  endfunction

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Digit/control inputs and display pin outputs of the scan driver, bundled for
// connection between the counter datapath (master) and the driver (slave).
interface seg7_scan_driver_if #(
  parameter int N_DIGITS = 4
);

  logic [4*N_DIGITS-1:0] digits;
  logic [N_DIGITS-1:0]   dp_in;
  logic                  blank_lz;
  logic                  enable;
  logic [N_DIGITS-1:0]   an;
  logic [6:0]            seg;
  logic                  dp;
  logic                  frame;

  modport master (
    output digits, dp_in, blank_lz, enable,
    input  an, seg, dp, frame
  );

  modport slave (
    input  digits, dp_in, blank_lz, enable,
    output an, seg, dp, frame
  );

endinterface

// File: rtl/seg7_scan_driver_bcd_to_seg7.sv
// Combinational BCD to active-low seven-segment decoder; codes above 9 show a dash.
module bcd_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_DASH;
    if (bcd_i <= 4'd9) begin
      seg_o = DIGIT_CODES[bcd_i];
    end
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexes N BCD digits onto a common-anode display; digits are captured once
// per frame so a scan never mixes values from two different counter states.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int N_DIGITS = 4,
  parameter int SCAN_DIV = 100000
) (
  input  logic               clk,
  input  logic               rst_n,
  seg7_scan_driver_if.slave  bus
);

  localparam int PW = prescaler_width(SCAN_DIV);
  localparam int IW = $clog2(N_DIGITS);
  localparam logic [PW-1:0] CNT_MAX = PW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_MAX = IW'(N_DIGITS - 1);

  logic [PW-1:0]         cnt_q, cnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [4*N_DIGITS-1:0] snap_q, snap_d;
  logic [N_DIGITS-1:0]   dp_snap_q, dp_snap_d;
  logic                  lz_snap_q, lz_snap_d;
  logic                  frame_q, frame_d;
  logic [N_DIGITS-1:0]   an_q, an_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;

  logic                  tick;
  logic                  wrap;
  logic [N_DIGITS-1:0]   digit_zero;
  logic [N_DIGITS-1:0]   zero_from;
  logic [3:0]            cur_digit;
  logic [6:0]            dec_seg;
  logic                  blank_cur;

  assign tick = (cnt_q == CNT_MAX);
  assign wrap = tick && (idx_q == IDX_MAX);

  // zero_from[k]: snapshot digits k..N_DIGITS-1 are all zero (invalid codes are non-zero).
  genvar gi;
  generate
    for (gi = 0; gi < N_DIGITS; gi++) begin : g_zero
      assign digit_zero[gi] = (snap_q[4*gi +: 4] == 4'd0);
      if (gi == N_DIGITS - 1) begin : g_top
        assign zero_from[gi] = digit_zero[gi];
      end else begin : g_chain
        assign zero_from[gi] = digit_zero[gi] & zero_from[gi+1];
      end
    end
  endgenerate

  assign cur_digit = snap_q[4*idx_q +: 4];
  assign blank_cur = lz_snap_q && (idx_q != '0) && zero_from[idx_q];

  bcd_to_seg7 u_dec (
    .bcd_i (cur_digit),
    .seg_o (dec_seg)
  );

  always_comb begin
    cnt_d     = tick ? '0 : cnt_q + 1'b1;
    idx_d     = idx_q;
    snap_d    = snap_q;
    dp_snap_d = dp_snap_q;
    lz_snap_d = lz_snap_q;
    frame_d   = wrap;
    if (tick) begin
      idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
    end
    if (wrap) begin
      snap_d    = bus.digits;
      dp_snap_d = bus.dp_in;
      lz_snap_d = bus.blank_lz;
    end
  end

  // Output stage works from the current idx/snapshot, so pins lag the scan by one clock.
  always_comb begin
    an_d  = '1;
    seg_d = SEG_OFF;
    dp_d  = 1'b1;
    if (bus.enable) begin
      an_d  = ~(N_DIGITS'(1) << idx_q);
      seg_d = blank_cur ? SEG_OFF : dec_seg;
      dp_d  = ~dp_snap_q[idx_q];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      idx_q     <= '0;
      snap_q    <= '0;
      dp_snap_q <= '0;
      lz_snap_q <= 1'b0;
      frame_q   <= 1'b0;
      an_q      <= '1;
      seg_q     <= SEG_OFF;
      dp_q      <= 1'b1;
    end else begin
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      snap_q    <= snap_d;
      dp_snap_q <= dp_snap_d;
      lz_snap_q <= lz_snap_d;
      frame_q   <= frame_d;
      an_q      <= an_d;
      seg_q     <= seg_d;
      dp_q      <= dp_d;
    end
  end

  assign bus.an    = an_q;
  assign bus.seg   = seg_q;
  assign bus.dp    = dp_q;
  assign bus.frame = frame_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with N_DIGITS=4, SCAN_DIV=4 (16-clock frames).
module tb_seg7_scan_driver;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  seg7_scan_driver_if #(.N_DIGITS(4)) bus ();

  seg7_scan_driver #(
    .N_DIGITS (4),
    .SCAN_DIV (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_pins(input string tag, input logic [3:0] an, input logic [6:0] seg,
                          input logic dp);
    chk({tag, ".an"},  16'(bus.an),  16'(an));
    chk({tag, ".seg"}, 16'(bus.seg), 16'(seg));
    chk({tag, ".dp"},  16'(bus.dp),  16'(dp));
    $display("%t %s an=%b seg=%b dp=%b frame=%b", $time, tag, bus.an, bus.seg, bus.dp, bus.frame);
  endtask

  // Advance until FRAME is seen at a falling edge, with a bounded cycle budget.
  task automatic wait_frame(input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.frame !== 1'b1 && n < 40);
    chk({tag, ".frame_seen"}, 16'(bus.frame), 16'd1);
  endtask

  // Called at the falling edge where FRAME=1; checks all four slots and the next FRAME.
  task automatic check_slots(input string tag, input logic [0:3][6:0] segs,
                             input logic [0:3] dps, input bit change,
                             input logic [15:0] new_digits);
    logic [3:0] an_exp;
    for (int s = 0; s < 4; s++) begin
      @(negedge clk);
      an_exp = ~(4'b0001 << s);
      chk_pins($sformatf("%s.slot%0d", tag, s), an_exp, segs[s], dps[s]);
      if (s == 0) chk({tag, ".frame_low"}, 16'(bus.frame), 16'd0);
      if (change && s == 1) bus.digits = new_digits;
      repeat (3) @(negedge clk);
    end
    chk({tag, ".frame_period"}, 16'(bus.frame), 16'd1);
  endtask

  initial begin
    bus.digits   = 16'h0000;
    bus.dp_in    = 4'b0000;
    bus.blank_lz = 1'b0;
    bus.enable   = 1'b1;

    // Reset state
    #12;
    chk_pins("reset", 4'hF, 7'h7F, 1'b1);
    chk("reset.frame", 16'(bus.frame), 16'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // First frame after reset shows the zero snapshot
    @(negedge clk);
    chk_pins("first", 4'hE, 7'b1000000, 1'b1);

    // Scan of 1234
    bus.digits = 16'h1234;
    wait_frame("scan");
    check_slots("scan", {7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001}, 4'b1111, 1'b0, 16'h0);

    // Mid-frame change: remainder still 1234, then 5678 on the next frame
    check_slots("snap_old", {7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001}, 4'b1111,
                1'b1, 16'h5678);
    check_slots("snap_new", {7'b0000000, 7'b1111000, 7'b0000010, 7'b0010010}, 4'b1111,
                1'b0, 16'h0);

    // ENABLE dropped for 10 clocks
    bus.enable = 1'b0;
    @(negedge clk);
    chk_pins("dark", 4'hF, 7'h7F, 1'b1);
    chk("dark.frame", 16'(bus.frame), 16'd0);
    repeat (9) @(negedge clk);
    bus.enable = 1'b1;
    @(negedge clk);
    chk_pins("restore", 4'hB, 7'b0000010, 1'b1);
    repeat (5) @(negedge clk);
    chk("restore.frame", 16'(bus.frame), 16'd1);

    // Leading-zero blanking
    bus.digits   = 16'h0070;
    bus.blank_lz = 1'b1;
    wait_frame("lz70");
    check_slots("lz70", {7'b1000000, 7'b1111000, 7'h7F, 7'h7F}, 4'b1111, 1'b0, 16'h0);
    bus.digits = 16'h0000;
    wait_frame("lz00");
    check_slots("lz00", {7'b1000000, 7'h7F, 7'h7F, 7'h7F}, 4'b1111, 1'b0, 16'h0);

    // Invalid code and decimal point
    bus.digits   = 16'h00A9;
    bus.dp_in    = 4'b0010;
    bus.blank_lz = 1'b0;
    wait_frame("inv");
    check_slots("inv", {7'b0010000, 7'b0111111, 7'b1000000, 7'b1000000}, 4'b1011,
                1'b0, 16'h0);
    bus.blank_lz = 1'b1;
    wait_frame("inv_lz");
    check_slots("inv_lz", {7'b0010000, 7'b0111111, 7'h7F, 7'h7F}, 4'b1011, 1'b0, 16'h0);

    // Asynchronous reset mid-scan
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_pins("async_rst", 4'hF, 7'h7F, 1'b1);
    chk("async_rst.frame", 16'(bus.frame), 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_pins("post_rst", 4'hE, 7'b1000000, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
